// File: rtl/mprj_wb_timeout_bridge.sv
// Registered Wishbone bridge from the management core to the user area.
// Unacknowledged user cycles are cut off after TIMEOUT cycles; the first fault is logged.
module mprj_wb_timeout_bridge #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    input  logic        wb_iena,
    output logic        u_cyc_o,
    output logic        u_stb_o,
    output logic        u_we_o,
    output logic [3:0]  u_sel_o,
    output logic [31:0] u_adr_o,
    output logic [31:0] u_dat_o,
    input  logic        u_ack_i,
    input  logic [31:0] u_dat_i,
    input  logic        to_clr,
    output logic        to_flag,
    output logic [31:0] to_adr,
    output logic [7:0]  to_count
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [31:0]   mdat_q, mdat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;
    logic [31:0]   tadr_q, tadr_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic          timeout;

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            mdat_q  <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            tadr_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            mdat_q  <= mdat_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            tadr_q  <= tadr_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        mdat_d  = mdat_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        tadr_d  = tadr_q;
        tcnt_d  = tcnt_q;
        timeout = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    we_d   = m_we_i;
                    sel_d  = m_sel_i;
                    adr_d  = m_adr_i;
                    wdat_d = m_dat_i;
                    if (wb_iena) begin
                        cyc_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = REQ;
                    end else begin
                        mdat_d  = ERR_DATA;
                        state_d = RESP;
                    end
                end
            end
            REQ: begin
                if (!m_cyc_i) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else if (u_ack_i) begin
                    mdat_d  = u_dat_i;
                    cyc_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    mdat_d  = ERR_DATA;
                    cyc_d   = 1'b0;
                    timeout = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (to_clr) begin
            flag_d = 1'b0;
            tadr_d = '0;
            tcnt_d = '0;
        end
        // A timeout on the clearing edge is recorded as the first fault.
        if (timeout) begin
            flag_d = 1'b1;
            if (!flag_q || to_clr) tadr_d = adr_q;
            if (to_clr) tcnt_d = 8'd1;
            else if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end
    end

    assign m_ack_o  = (state_q == RESP);
    assign m_dat_o  = mdat_q;
    assign u_cyc_o  = cyc_q;
    assign u_stb_o  = cyc_q;
    assign u_we_o   = we_q;
    assign u_sel_o  = sel_q;
    assign u_adr_o  = adr_q;
    assign u_dat_o  = wdat_q;
    assign to_flag  = flag_q;
    assign to_adr   = tadr_q;
    assign to_count = tcnt_q;

endmodule

// File: tb/tb_mprj_wb_timeout_bridge.sv
// Scoreboard bench for mprj_wb_timeout_bridge with a short timeout.
module tb_mprj_wb_timeout_bridge;

    localparam int unsigned TO = 16;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;
    logic        m_ack_o;
    logic [31:0] m_dat_o;
    logic        wb_iena;
    logic        u_cyc_o, u_stb_o, u_we_o;
    logic [3:0]  u_sel_o;
    logic [31:0] u_adr_o, u_dat_o;
    logic        u_ack;
    logic [31:0] u_dat;
    logic        to_clr;
    logic        to_flag;
    logic [31:0] to_adr;
    logic [7:0]  to_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [144:0] outs;

    assign outs = {m_ack_o, m_dat_o, u_cyc_o, u_stb_o, u_we_o, u_sel_o,
                   u_adr_o, u_dat_o, to_flag, to_adr, to_count};

    mprj_wb_timeout_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .core_clk(clk), .core_rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_ack_o(m_ack_o), .m_dat_o(m_dat_o), .wb_iena(wb_iena),
        .u_cyc_o(u_cyc_o), .u_stb_o(u_stb_o), .u_we_o(u_we_o),
        .u_sel_o(u_sel_o), .u_adr_o(u_adr_o), .u_dat_o(u_dat_o),
        .u_ack_i(u_ack), .u_dat_i(u_dat), .to_clr(to_clr),
        .to_flag(to_flag), .to_adr(to_adr), .to_count(to_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp();
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        else exp = 'x;
    endtask

    // Cycle c is the cycle after the c-th edge following the request drive.
    task automatic do_txn(input logic we, input logic [31:0] adr,
                          input logic [3:0] sel, input logic [31:0] dat,
                          input int ack_at, input logic [31:0] udat,
                          input int clr_at,
                          output int stb_n, output int ack_cyc,
                          output int ack_n, output logic [31:0] rdat,
                          output logic [70:0] snap);
        stb_n = 0; ack_cyc = 0; ack_n = 0; rdat = '0; snap = '0;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we;
        m_adr = adr; m_sel = sel; m_dat = dat;
        for (int c = 1; c <= 60; c++) begin
            tick();
            u_ack = 1'b0;
            to_clr = 1'b0;
            if (c == 1)
                snap = {u_cyc_o, u_stb_o, u_we_o, u_sel_o, u_adr_o, u_dat_o};
            if (u_cyc_o || u_stb_o) stb_n++;
            if (m_ack_o) begin
                ack_n++;
                if (ack_cyc == 0) begin
                    ack_cyc = c;
                    rdat = m_dat_o;
                    m_cyc = 1'b0;
                    m_stb = 1'b0;
                end
            end
            if (c == ack_at) begin
                u_ack = 1'b1;
                u_dat = udat;
            end
            if (c == clr_at) to_clr = 1'b1;
            if (ack_cyc != 0 && c >= ack_cyc + 2 && c > ack_at) break;
        end
        m_cyc = 1'b0; m_stb = 1'b0; u_ack = 1'b0; to_clr = 1'b0;
    endtask

    int sn, ac, an;
    logic [31:0] rd;
    logic [70:0] sp;

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read();
        exp_q.push_back(32'h1234_5678);
        do_txn(1'b0, 32'h3000_0010, 4'hF, 32'h0, 4, 32'h1234_5678, 0,
               sn, ac, an, rd, sp);
        checks++;
        if (sp !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'h0}) begin
            errors++;
            $display("FAIL rd_fields got %h", sp);
        end
        checks++;
        if (sn !== 4 || ac !== 5 || an !== 1) begin
            errors++;
            $display("FAIL rd_timing got stb=%0d ack@%0d n=%0d want 4 5 1",
                     sn, ac, an);
        end
        pop_exp();
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL rd_data got %h want %h", rd, exp);
        end
        checks++;
        if (to_flag !== 1'b0) begin
            errors++;
            $display("FAIL rd_flag got %b want 0", to_flag);
        end
    endtask

    task automatic test_write();
        exp_q.push_back(32'h1234_5678);
        do_txn(1'b1, 32'h3000_0004, 4'b0011, 32'hA5A5_5A5A, 1,
               32'h1234_5678, 0, sn, ac, an, rd, sp);
        checks++;
        if (sp !== {1'b1, 1'b1, 1'b1, 4'b0011, 32'h3000_0004,
                    32'hA5A5_5A5A}) begin
            errors++;
            $display("FAIL wr_fields got %h", sp);
        end
        checks++;
        if (sn !== 1 || ac !== 2 || an !== 1) begin
            errors++;
            $display("FAIL wr_timing got stb=%0d ack@%0d n=%0d want 1 2 1",
                     sn, ac, an);
        end
        pop_exp();
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL wr_data got %h want %h", rd, exp);
        end
    endtask

    task automatic test_isolated();
        wb_iena = 1'b0;
        exp_q.push_back(ERR);
        do_txn(1'b0, 32'h3000_0600, 4'hF, 32'h0, 0, 32'h0, 0,
               sn, ac, an, rd, sp);
        wb_iena = 1'b1;
        checks++;
        if (sn !== 0 || ac !== 1 || an !== 1) begin
            errors++;
            $display("FAIL iso_timing got ucyc=%0d ack@%0d n=%0d want 0 1 1",
                     sn, ac, an);
        end
        pop_exp();
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL iso_data got %h want %h", rd, exp);
        end
        checks++;
        if ({to_flag, to_count} !== 9'd0) begin
            errors++;
            $display("FAIL iso_status got %b/%0d want 0/0", to_flag, to_count);
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back(ERR);
        do_txn(1'b0, 32'h3000_0100, 4'hF, 32'h0, 0, 32'h0, 0,
               sn, ac, an, rd, sp);
        checks++;
        if (sn !== TO || ac !== TO + 1 || an !== 1) begin
            errors++;
            $display("FAIL to_timing got stb=%0d ack@%0d n=%0d want %0d %0d 1",
                     sn, ac, an, TO, TO + 1);
        end
        pop_exp();
        checks++;
        if (rd !== exp) begin
            errors++;
            $display("FAIL to_data got %h want %h", rd, exp);
        end
        checks++;
        if ({to_flag, to_adr, to_count} !== {1'b1, 32'h3000_0100, 8'd1}) begin
            errors++;
            $display("FAIL to_status1 got %b %h %0d want 1 30000100 1",
                     to_flag, to_adr, to_count);
        end
        do_txn(1'b0, 32'h3000_0200, 4'hF, 32'h0, 0, 32'h0, 0,
               sn, ac, an, rd, sp);
        checks++;
        if ({to_flag, to_adr, to_count} !== {1'b1, 32'h3000_0100, 8'd2}) begin
            errors++;
            $display("FAIL to_status2 got %b %h %0d want 1 30000100 2",
                     to_flag, to_adr, to_count);
        end
        do_txn(1'b0, 32'h3000_0300, 4'hF, 32'h0, 0, 32'h0, TO,
               sn, ac, an, rd, sp);
        checks++;
        if ({to_flag, to_adr, to_count} !== {1'b1, 32'h3000_0300, 8'd1}) begin
            errors++;
            $display("FAIL to_clr_race got %b %h %0d want 1 30000300 1",
                     to_flag, to_adr, to_count);
        end
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        checks++;
        if ({to_flag, to_adr, to_count} !== 41'd0) begin
            errors++;
            $display("FAIL to_clr got %b %h %0d want 0 0 0",
                     to_flag, to_adr, to_count);
        end
    endtask

    task automatic test_ack_race();
        exp_q.push_back(32'hCAFE_0001);
        do_txn(1'b0, 32'h3000_0400, 4'hF, 32'h0, TO, 32'hCAFE_0001, 0,
               sn, ac, an, rd, sp);
        pop_exp();
        checks++;
        if (rd !== exp || ac !== TO + 1 || sn !== TO) begin
            errors++;
            $display("FAIL race_ack got %h ack@%0d stb=%0d want %h %0d %0d",
                     rd, ac, sn, exp, TO + 1, TO);
        end
        checks++;
        if ({to_flag, to_count} !== 9'd0) begin
            errors++;
            $display("FAIL race_status got %b/%0d want 0/0", to_flag, to_count);
        end
        exp_q.push_back(ERR);
        do_txn(1'b0, 32'h3000_0500, 4'hF, 32'h0, TO + 1, 32'hCAFE_0002, 0,
               sn, ac, an, rd, sp);
        pop_exp();
        checks++;
        if (rd !== exp || ac !== TO + 1 || an !== 1) begin
            errors++;
            $display("FAIL late_ack got %h ack@%0d n=%0d want %h %0d 1",
                     rd, ac, an, exp, TO + 1);
        end
        checks++;
        if (m_dat_o !== ERR || u_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL late_hold got %h cyc=%b want %h 0",
                     m_dat_o, u_cyc_o, ERR);
        end
        checks++;
        if ({to_flag, to_adr, to_count} !== {1'b1, 32'h3000_0500, 8'd1}) begin
            errors++;
            $display("FAIL late_status got %b %h %0d want 1 30000500 1",
                     to_flag, to_adr, to_count);
        end
    endtask

    task automatic test_abort();
        int acks = 0;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
        m_adr = 32'h3000_0700; m_sel = 4'hF;
        tick();
        checks++;
        if (u_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_issue got %b want 1", u_cyc_o);
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        tick();
        checks++;
        if (u_cyc_o !== 1'b0 || u_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop got %b%b want 00", u_cyc_o, u_stb_o);
        end
        for (int c = 0; c < 4; c++) begin
            if (m_ack_o) acks++;
            tick();
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL abort_ack got %0d acks want 0", acks);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int last = 0;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
        m_adr = 32'h3000_0800; m_sel = 4'hF;
        for (int c = 1; c <= 12; c++) begin
            tick();
            u_ack = 1'b0;
            if (m_ack_o) begin
                acks++;
                pop_exp();
                checks++;
                if (m_dat_o !== exp || (last != 0 && c - last != 3)) begin
                    errors++;
                    $display("FAIL b2b_ack got %h gap %0d want %h gap 3",
                             m_dat_o, c - last, exp);
                end
                last = c;
            end
            if (u_stb_o) begin
                u_ack = 1'b1;
                u_dat = 32'hB000_0000 | 32'(c);
                exp_q.push_back(u_dat);
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0; u_ack = 1'b0;
        tick();
        checks++;
        if (acks !== 4 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count got %0d acks left %0d want 4 0",
                     acks, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_saturation();
        int good = 0;
        for (int i = 0; i < 300; i++) begin
            do_txn(1'b0, 32'h4000_0000 + 32'(i), 4'hF, 32'h0, 0, 32'h0, 0,
                   sn, ac, an, rd, sp);
            if (rd === ERR && ac == TO + 1) good++;
        end
        checks++;
        if (good !== 300) begin
            errors++;
            $display("FAIL sat_txns got %0d good want 300", good);
        end
        checks++;
        if ({to_flag, to_adr, to_count} !== {1'b1, 32'h3000_0500, 8'd255}) begin
            errors++;
            $display("FAIL sat_status got %b %h %0d want 1 30000500 255",
                     to_flag, to_adr, to_count);
        end
    endtask

    task automatic test_reset_mid_req();
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1;
        m_adr = 32'h3000_0900; m_sel = 4'hF; m_dat = 32'h5555_AAAA;
        tick();
        checks++;
        if (u_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got %b want 1", u_cyc_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_async got %h want 0", outs);
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(32'h600D_F00D);
        do_txn(1'b0, 32'h3000_0A00, 4'hF, 32'h0, 2, 32'h600D_F00D, 0,
               sn, ac, an, rd, sp);
        pop_exp();
        checks++;
        if (rd !== exp || ac !== 3 || an !== 1) begin
            errors++;
            $display("FAIL rst_after got %h ack@%0d n=%0d want %h 3 1",
                     rd, ac, an, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_sel = '0; m_adr = '0; m_dat = '0;
        wb_iena = 1'b1; u_ack = 1'b0; u_dat = '0; to_clr = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_isolated();
        test_timeout();
        test_ack_race();
        test_abort();
        test_back_to_back();
        test_saturation();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
